// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with held-redirect buffer, trap/return
// redirection with EPC/cause capture, misaligned-target detection and fetch counter.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0080),
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [XLEN-1:0]  branch_tgt_i,
  input  logic             trap_i,
  input  logic [3:0]       trap_cause_i,
  input  logic             mret_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             valid_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  epc_o,
  output logic [3:0]       cause_o,
  output logic [XLEN-1:0]  badaddr_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [0:0]      ST_IDLE        = 1'b0;
  localparam logic [0:0]      ST_RUN         = 1'b1;
  localparam logic [XLEN-1:0] STEP_V         = XLEN'(STEP);
  // STEP is a power of two, so STEP-1 masks exactly the offset bits; zero when STEP = 1.
  localparam logic [XLEN-1:0] ALIGN_MASK     = XLEN'(STEP - 1);
  localparam logic [3:0]      CAUSE_MISALIGN = 4'hA;

  logic [0:0]       state_r,    state_s;
  logic [XLEN-1:0]  pc_r,       pc_s;
  logic             valid_r,    valid_s;
  logic             trap_r,     trap_s;
  logic [XLEN-1:0]  epc_r,      epc_s;
  logic [3:0]       cause_r,    cause_s;
  logic [XLEN-1:0]  badaddr_r,  badaddr_s;
  logic [CNT_W-1:0] cnt_r,      cnt_s;
  logic             pend_v_r,   pend_v_s;
  logic [XLEN-1:0]  pend_tgt_r, pend_tgt_s;
  logic             misalign_s;
  logic             adv_s;

  // Next-state selection: IDLE/RUN control and the RUN redirect priority chain.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    valid_s    = 1'b0;
    trap_s     = 1'b0;
    epc_s      = epc_r;
    cause_s    = cause_r;
    badaddr_s  = badaddr_r;
    pend_v_s   = pend_v_r;
    pend_tgt_s = pend_tgt_r;
    adv_s      = 1'b0;
    misalign_s = branch_i && ((branch_tgt_i & ALIGN_MASK) != {XLEN{1'b0}});

    case (state_r)
      ST_IDLE: begin
        pc_s     = RESET_VEC;
        pend_v_s = 1'b0;
        if (start_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!start_i) begin
          state_s  = ST_IDLE;
          pc_s     = RESET_VEC;
          pend_v_s = 1'b0;
        end else begin
          valid_s = !stall_i;
          if (trap_i || misalign_s) begin
            pc_s      = TRAP_VEC;
            epc_s     = pc_r;
            trap_s    = 1'b1;
            pend_v_s  = 1'b0;
            adv_s     = 1'b1;
            cause_s   = trap_i ? trap_cause_i : CAUSE_MISALIGN;
            badaddr_s = trap_i ? {XLEN{1'b0}} : branch_tgt_i;
          end else if (mret_i) begin
            pc_s     = epc_r;
            pend_v_s = 1'b0;
            adv_s    = 1'b1;
          end else if (branch_i && !stall_i) begin
            // A fresh branch at stall release supersedes any held redirect.
            pc_s     = branch_tgt_i;
            pend_v_s = 1'b0;
            adv_s    = 1'b1;
          end else if (branch_i) begin
            pend_tgt_s = branch_tgt_i;
            pend_v_s   = 1'b1;
          end else if (stall_i) begin
            pc_s = pc_r;
          end else if (pend_v_r) begin
            pc_s     = pend_tgt_r;
            pend_v_s = 1'b0;
            adv_s    = 1'b1;
          end else begin
            pc_s  = pc_r + STEP_V;
            adv_s = 1'b1;
          end
        end
      end
      default: begin
        state_s  = ST_IDLE;
        pc_s     = RESET_VEC;
        pend_v_s = 1'b0;
      end
    endcase

    if (adv_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VEC;
      valid_r    <= 1'b0;
      trap_r     <= 1'b0;
      epc_r      <= {XLEN{1'b0}};
      cause_r    <= 4'h0;
      badaddr_r  <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      pend_v_r   <= 1'b0;
      pend_tgt_r <= {XLEN{1'b0}};
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      valid_r    <= valid_s;
      trap_r     <= trap_s;
      epc_r      <= epc_s;
      cause_r    <= cause_s;
      badaddr_r  <= badaddr_s;
      cnt_r      <= cnt_s;
      pend_v_r   <= pend_v_s;
      pend_tgt_r <= pend_tgt_s;
    end
  end

  assign pc_o        = pc_r;
  assign valid_o     = valid_r;
  assign trap_o      = trap_r;
  assign epc_o       = epc_r;
  assign cause_o     = cause_r;
  assign badaddr_o   = badaddr_r;
  assign fetch_cnt_o = cnt_r;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with fixed expectations, then randomized
// traffic checked against a rule-level reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, start, stall, branch, trap, mret;
  logic [31:0] tgt;
  logic [3:0]  cause_in;
  logic [31:0] pc_o, epc_o, badaddr_o;
  logic        valid_o, trap_o;
  logic [3:0]  cause_o;
  logic [15:0] cnt_o;

  logic        rst8, start8;
  logic [7:0]  pc8, epc8, bad8;
  logic        valid8, trap8;
  logic [3:0]  cause8;
  logic [7:0]  cnt8;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic        m_run, m_valid, m_trap, m_pv;
  logic [31:0] m_pc, m_epc, m_bad, m_ptgt;
  logic [3:0]  m_cause;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .branch_i(branch), .branch_tgt_i(tgt), .trap_i(trap),
    .trap_cause_i(cause_in), .mret_i(mret),
    .pc_o(pc_o), .valid_o(valid_o), .trap_o(trap_o), .epc_o(epc_o),
    .cause_o(cause_o), .badaddr_o(badaddr_o), .fetch_cnt_o(cnt_o)
  );

  pc_unit #(.XLEN(8), .RESET_VEC(8'hF0), .TRAP_VEC(8'h80), .STEP(4), .CNT_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .start_i(start8), .stall_i(1'b0),
    .branch_i(1'b0), .branch_tgt_i(8'h00), .trap_i(1'b0),
    .trap_cause_i(4'h0), .mret_i(1'b0),
    .pc_o(pc8), .valid_o(valid8), .trap_o(trap8), .epc_o(epc8),
    .cause_o(cause8), .badaddr_o(bad8), .fetch_cnt_o(cnt8)
  );

  task automatic model_step();
    logic adv;
    adv     = 1'b0;
    m_trap  = 1'b0;
    m_valid = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pc = 32'h0; m_epc = 32'h0; m_cause = 4'h0;
      m_bad = 32'h0; m_cnt = 16'h0; m_pv = 1'b0;
    end else if (!m_run) begin
      m_run = start; m_pc = 32'h0; m_pv = 1'b0;
    end else if (!start) begin
      m_run = 1'b0; m_pc = 32'h0; m_pv = 1'b0;
    end else begin
      m_valid = !stall;
      if (trap || (branch && (tgt % 32'd4 != 32'd0))) begin
        m_epc = m_pc; m_pc = 32'h80; m_trap = 1'b1; m_pv = 1'b0; adv = 1'b1;
        m_cause = trap ? cause_in : 4'hA;
        m_bad   = trap ? 32'h0 : tgt;
      end else if (mret) begin
        m_pc = m_epc; m_pv = 1'b0; adv = 1'b1;
      end else if (branch && !stall) begin
        m_pc = tgt; m_pv = 1'b0; adv = 1'b1;
      end else if (branch) begin
        m_ptgt = tgt; m_pv = 1'b1;
      end else if (stall) begin
        adv = 1'b0;
      end else if (m_pv) begin
        m_pc = m_ptgt; m_pv = 1'b0; adv = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; adv = 1'b1;
      end
    end
    if (adv) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch = 1'b0; trap = 1'b0; mret = 1'b0;
    tgt = 32'h0; cause_in = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear_inputs();
    rst8 = 1'b1; start8 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (pc_o !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0); else n_pass++;
    n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_o); else n_pass++;
    n_total++; if (trap_o !== 1'b0) $display("FAIL reset_trap got %b exp 0", trap_o); else n_pass++;
    n_total++; if (epc_o !== 32'h0 || cause_o !== 4'h0 || badaddr_o !== 32'h0)
      $display("FAIL reset_epc_cause_bad got %h/%h/%h exp 0/0/0", epc_o, cause_o, badaddr_o); else n_pass++;
    n_total++; if (cnt_o !== 16'h0) $display("FAIL reset_cnt got %0d exp 0", cnt_o); else n_pass++;
    // IDLE ignores every other input
    branch = 1'b1; tgt = 32'h100; trap = 1'b1; cause_in = 4'h7;
    tick();
    n_total++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || trap_o !== 1'b0 || cause_o !== 4'h0)
      $display("FAIL idle_ignore got pc %h v %b t %b c %h exp 0/0/0/0", pc_o, valid_o, trap_o, cause_o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (pc_o !== exp_pc[i]) $display("FAIL seq_pc%0d got %h exp %h", i, pc_o, exp_pc[i]); else n_pass++;
      n_total++; if (valid_o !== (i != 0)) $display("FAIL seq_valid%0d got %b exp %b", i, valid_o, (i != 0)); else n_pass++;
    end
    n_total++; if (cnt_o !== 16'd3) $display("FAIL seq_cnt got %0d exp 3", cnt_o); else n_pass++;
  endtask

  task automatic test_stall_branch();
    tick();
    n_total++; if (pc_o !== 32'h10) $display("FAIL stall_pre got %h exp %h", pc_o, 32'h10); else n_pass++;
    stall = 1'b1; branch = 1'b1; tgt = 32'h40;
    tick();
    n_total++; if (pc_o !== 32'h10 || valid_o !== 1'b0) $display("FAIL stall_c1 got %h v %b exp 10 v 0", pc_o, valid_o); else n_pass++;
    branch = 1'b0;
    tick();
    n_total++; if (pc_o !== 32'h10 || valid_o !== 1'b0) $display("FAIL stall_c2 got %h v %b exp 10 v 0", pc_o, valid_o); else n_pass++;
    stall = 1'b0;
    tick();
    n_total++; if (pc_o !== 32'h40 || valid_o !== 1'b1) $display("FAIL stall_rel got %h v %b exp 40 v 1", pc_o, valid_o); else n_pass++;
    tick();
    n_total++; if (pc_o !== 32'h44) $display("FAIL stall_next got %h exp %h", pc_o, 32'h44); else n_pass++;
    n_total++; if (cnt_o !== 16'd6) $display("FAIL stall_cnt got %0d exp 6", cnt_o); else n_pass++;
    // new branch at release overrides the held one
    stall = 1'b1; branch = 1'b1; tgt = 32'h100;
    tick();
    stall = 1'b0; tgt = 32'h200;
    tick();
    branch = 1'b0;
    n_total++; if (pc_o !== 32'h200) $display("FAIL newbr_wins got %h exp %h", pc_o, 32'h200); else n_pass++;
    tick();
    n_total++; if (pc_o !== 32'h204) $display("FAIL newbr_discard got %h exp %h", pc_o, 32'h204); else n_pass++;
  endtask

  task automatic test_misalign();
    branch = 1'b1; tgt = 32'h20;
    tick();
    tgt = 32'h42;
    tick();
    branch = 1'b0;
    n_total++; if (pc_o !== 32'h80) $display("FAIL mis_pc got %h exp %h", pc_o, 32'h80); else n_pass++;
    n_total++; if (trap_o !== 1'b1) $display("FAIL mis_trap got %b exp 1", trap_o); else n_pass++;
    n_total++; if (epc_o !== 32'h20 || cause_o !== 4'hA || badaddr_o !== 32'h42)
      $display("FAIL mis_info got %h/%h/%h exp 20/a/42", epc_o, cause_o, badaddr_o); else n_pass++;
    tick();
    n_total++; if (trap_o !== 1'b0 || pc_o !== 32'h84) $display("FAIL mis_after got t %b pc %h exp 0/84", trap_o, pc_o); else n_pass++;
  endtask

  task automatic test_trap_mret();
    branch = 1'b1; tgt = 32'h30;
    tick();
    branch = 1'b0; trap = 1'b1; cause_in = 4'h3; mret = 1'b1;
    tick();
    trap = 1'b0; mret = 1'b0;
    n_total++; if (pc_o !== 32'h80 || trap_o !== 1'b1) $display("FAIL trapwin got %h t %b exp 80 t 1", pc_o, trap_o); else n_pass++;
    n_total++; if (epc_o !== 32'h30 || cause_o !== 4'h3 || badaddr_o !== 32'h0)
      $display("FAIL trapwin_info got %h/%h/%h exp 30/3/0", epc_o, cause_o, badaddr_o); else n_pass++;
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    n_total++; if (pc_o !== 32'h30) $display("FAIL mret_pc got %h exp %h", pc_o, 32'h30); else n_pass++;
    tick();
    n_total++; if (pc_o !== 32'h34) $display("FAIL mret_next got %h exp %h", pc_o, 32'h34); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1; trap = 1'b1; cause_in = 4'h5;
    tick();
    rst = 1'b0; trap = 1'b0;
    n_total++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || trap_o !== 1'b0)
      $display("FAIL rst_mid got pc %h v %b t %b exp 0/0/0", pc_o, valid_o, trap_o); else n_pass++;
    n_total++; if (epc_o !== 32'h0 || cause_o !== 4'h0 || badaddr_o !== 32'h0 || cnt_o !== 16'h0)
      $display("FAIL rst_mid_info got %h/%h/%h/%0d exp 0/0/0/0", epc_o, cause_o, badaddr_o, cnt_o); else n_pass++;
    tick(); tick();
    n_total++; if (pc_o !== 32'h4) $display("FAIL rst_restart got %h exp %h", pc_o, 32'h4); else n_pass++;
    start = 1'b0; trap = 1'b1; cause_in = 4'h5;
    tick();
    trap = 1'b0;
    n_total++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || trap_o !== 1'b0 || cause_o !== 4'h0)
      $display("FAIL stop_idle got pc %h v %b t %b c %h exp 0/0/0/0", pc_o, valid_o, trap_o, cause_o); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp8 [5] = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00};
    rst8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (pc8 !== exp8[i]) $display("FAIL wrap_pc%0d got %h exp %h", i, pc8, exp8[i]); else n_pass++;
    end
    start8 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      start    = ($urandom_range(0, 15) != 0);
      stall    = ($urandom_range(0, 2) == 0);
      branch   = ($urandom_range(0, 3) == 0);
      tgt      = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      trap     = ($urandom_range(0, 15) == 0);
      cause_in = 4'($urandom);
      mret     = ($urandom_range(0, 9) == 0);
      tick();
      n_total++; if (pc_o !== m_pc) $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc_o, m_pc); else n_pass++;
      n_total++; if (valid_o !== m_valid) $display("FAIL rnd_valid cyc %0d got %b exp %b", i, valid_o, m_valid); else n_pass++;
      n_total++; if (trap_o !== m_trap) $display("FAIL rnd_trap cyc %0d got %b exp %b", i, trap_o, m_trap); else n_pass++;
      n_total++; if (epc_o !== m_epc) $display("FAIL rnd_epc cyc %0d got %h exp %h", i, epc_o, m_epc); else n_pass++;
      n_total++; if (cause_o !== m_cause) $display("FAIL rnd_cause cyc %0d got %h exp %h", i, cause_o, m_cause); else n_pass++;
      n_total++; if (badaddr_o !== m_bad) $display("FAIL rnd_bad cyc %0d got %h exp %h", i, badaddr_o, m_bad); else n_pass++;
      n_total++; if (cnt_o !== m_cnt) $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, cnt_o, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    m_ptgt = 32'h0;
    test_reset();
    test_sequential();
    test_stall_branch();
    test_misalign();
    test_trap_mret();
    test_reset_midrun();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
